sram_word_ctrl: RTL and testbench
=================================

// Module: sram_word_ctrl
// PURPOSE
//  Parametrised SRAM controller between the MEM stage and a narrow async SRAM.
//  Splits one WORD_W access into BEATS = WORD_W/SRAM_DW sequential SRAM beats, low slice first.
//  Latches the request at accept, so upstream operands may change while busy.
//  Inserts WAIT_CYC programmable settle cycles; asserts ready low while busy to stall the pipeline.
// PARAMETERS
//  ADDR_W    18  SRAM address width (beat-granular addressing)
//  SRAM_DW   16  SRAM data bus width
//  WORD_W    32  CPU word width; must be an integer multiple of SRAM_DW, BEATS >= 1
//  WAIT_CYC  1   idle settle cycles after the last beat (0 = none)
// PORTS
//  clk        in     1        clock, all state on rising edge
//  rst        in     1        reset, asynchronous, active-high
//  mem_w_en   in     1        write request, level, held until ready
//  mem_r_en   in     1        read request, level, held until ready
//  addr_in    in     32       word base address; [ADDR_W-1:0] used as SRAM address of beat 0
//  wr_data    in     WORD_W   store data
//  sram_dq    inout  SRAM_DW  SRAM data bus; driven only while sram_we_n=0, else high-Z
//  sram_addr  out    ADDR_W   SRAM address
//  sram_we_n  out    1        SRAM write enable, active-low
//  rd_data    out    WORD_W   assembled read word, registered
//  rd_valid   out    1        1-cycle pulse when rd_data is updated
//  ready      out    1        access complete / controller free
// BEHAVIOUR
//  Reset (async): state=IDLE, beat=0, rd_data=0, rd_valid=0, sram_we_n=1, sram_addr=0, sram_dq=Z.
//  States: IDLE, WR, RD, RD_TAIL, WAIT, DONE. beat counter width clog2(BEATS)+1.
//  IDLE: ready = ~mem_w_en & ~mem_r_en (combinational). On a request: latch addr, wr_data, and op.
//    Clear beat. Go to WR if mem_w_en, else RD. Write wins if both are asserted.
//  WR: sram_we_n=0, sram_addr = addr_lat + beat (mod 2^ADDR_W), sram_dq = wr_lat[beat*SRAM_DW +: SRAM_DW].
//    beat++. After beat BEATS-1, go to WAIT (or DONE if WAIT_CYC=0).
//  RD: sram_we_n=1, sram_addr = addr_lat + beat. sram_dq is sampled one cycle after its address cycle,
//    into slot beat-1 of the assembly register. RD_TAIL captures the last slot (sram_addr=0).
//    Then go to WAIT or DONE.
//  WAIT: counts WAIT_CYC cycles. Outputs: sram_we_n=1, sram_addr=0, dq=Z.
//  DONE: ready=1 for exactly 1 cycle, then IDLE.
//    For a read: rd_data <= assembly register and rd_valid=1 on the edge entering DONE.
//    For a write: rd_data is unchanged.
//  ready=0 in every state except IDLE and DONE. Request changes while busy are ignored.
//  Latency, request to ready=1 (cycle 0 = IDLE accept):
//    write: BEATS+WAIT_CYC+1 cycles; read: BEATS+WAIT_CYC+2 cycles.
//  Address wrap: addr_lat + beat wraps modulo 2^ADDR_W with no error flag.
//  Reset during any state aborts immediately; a partially written word is not rolled back.
//  A request held high through DONE is re-accepted in the following IDLE cycle; upstream must drop it.
//  WORD_W == SRAM_DW (BEATS=1): single beat, otherwise identical timing rules.
// STRUCTURE
//  sram_ctrl_pkg: state enum, function beats(WORD_W,SRAM_DW), localparam BEAT_W.
//  Sub-module sram_rd_assembler: BEATS x SRAM_DW slot register with load strobe and slot index,
//    async reset to 0.
//  Top: FSM, beat/wait counters, request latches, tri-state driver for sram_dq.
// TESTING (bench: behavioural SRAM model, 1-cycle read latency, 2^ADDR_W x SRAM_DW)
//  1 Write 0xDEADBEEF @0x100 (defaults) -> mem[0x100]=0xBEEF, mem[0x101]=0xDEAD; ready=1 at cycle 4.
//  2 Read @0x100 after test 1 -> rd_data=0xDEADBEEF, rd_valid pulse and ready=1 at cycle 5.
//  3 mem_w_en=mem_r_en=1, wr_data=0x12345678 @0x20 -> write performed, then rd_data unchanged.
//  4 Write 0xCAFEF00D @0x3FFFF -> mem[0x3FFFF]=0xF00D, mem[0x00000]=0xCAFE (wrap).
//  5 WORD_W=64, WAIT_CYC=0: write/read 0x0123456789ABCDEF @0x40 -> 4 beats, read-back matches;
//    read ready=1 at cycle 6.
//  6 Assert rst mid-read (RD beat 1) -> next cycle in IDLE, rd_data=0, sram_we_n=1, sram_dq=Z.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared state encodings and sizing helpers for the word-to-SRAM-beat controller.
package sram_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_RD_TAIL = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    function automatic int unsigned beats(input int unsigned word_w, input int unsigned sram_dw);
        return word_w / sram_dw;
    endfunction

    // Beat counter must be able to hold BEATS itself (read tail slot index + 1).
    function automatic int unsigned beat_w(input int unsigned n_beats);
        return $clog2(n_beats) + 1;
    endfunction

    localparam int unsigned BEAT_W = beat_w(beats(32, 16));

endpackage

// File: rtl/sram_rd_assembler.sv
// Collects SRAM read beats into a word-wide slot register, one slot per load strobe.
module sram_rd_assembler #(
    parameter int unsigned BEATS   = 2,
    parameter int unsigned SRAM_DW = 16,
    parameter int unsigned IDX_W   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [IDX_W-1:0]           idx,
    input  logic [SRAM_DW-1:0]         din,
    output logic [BEATS*SRAM_DW-1:0]   word_next_c
);

    logic [BEATS*SRAM_DW-1:0] slots;

    // Merged view lets the caller capture the last beat on the same edge it lands.
    always_comb begin
        word_next_c = slots;
        if (load) begin
            word_next_c[32'(idx)*SRAM_DW +: SRAM_DW] = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
        end else begin
            slots <= word_next_c;
        end
    end

endmodule

// File: rtl/sram_word_ctrl.sv
// MEM-stage controller that splits one CPU word into sequential narrow SRAM beats, low slice first.
module sram_word_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned SRAM_DW  = 16,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_w_en,
    input  logic                mem_r_en,
    input  logic [31:0]         addr_in,
    input  logic [WORD_W-1:0]   wr_data,
    inout  wire  [SRAM_DW-1:0]  sram_dq,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_we_n,
    output logic [WORD_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                ready
);

    localparam int unsigned BEATS  = beats(WORD_W, SRAM_DW);
    localparam int unsigned BW     = beat_w(BEATS);
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYC - 1);
    localparam logic [2:0]        TAIL_ST   = (WAIT_CYC == 0) ? ST_DONE : ST_WAIT;

    logic [2:0]          state, state_nxt;
    logic [BW-1:0]       beat, beat_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [ADDR_W-1:0]   addr_lat, addr_nxt;
    logic [WORD_W-1:0]   wr_lat;
    logic                op_wr;
    logic                accept_c;
    logic                we_n_nxt;
    logic [SRAM_DW-1:0]  dq_out, dout_nxt;
    logic                load_c;
    logic                rd_upd_c;
    logic [IDX_W-1:0]    idx_c;
    logic [WORD_W-1:0]   word_next_c;

    if (ADDR_W < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_in[31:ADDR_W];
    end

    // Next-state and next-output logic; SRAM pins are registered from these values.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        wait_nxt  = wait_cnt;
        we_n_nxt  = 1'b1;
        addr_nxt  = '0;
        dout_nxt  = dq_out;
        accept_c  = 1'b0;
        load_c    = 1'b0;
        ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = ~mem_w_en & ~mem_r_en;
                if (mem_w_en | mem_r_en) begin
                    accept_c = 1'b1;
                    beat_nxt = '0;
                    addr_nxt = addr_in[ADDR_W-1:0];
                    if (mem_w_en) begin
                        state_nxt = ST_WR;
                        we_n_nxt  = 1'b0;
                        dout_nxt  = wr_data[SRAM_DW-1:0];
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (beat == LAST_BEAT) begin
                    state_nxt = TAIL_ST;
                    wait_nxt  = '0;
                end else begin
                    beat_nxt = beat + 1'b1;
                    we_n_nxt = 1'b0;
                    addr_nxt = addr_lat + ADDR_W'(beat_nxt);
                    dout_nxt = SRAM_DW'(wr_lat >> (SRAM_DW * 32'(beat_nxt)));
                end
            end
            ST_RD: begin
                // Data for the previous address cycle is on the bus now.
                load_c   = (beat != '0);
                beat_nxt = beat + 1'b1;
                if (beat == LAST_BEAT) begin
                    state_nxt = ST_RD_TAIL;
                end else begin
                    addr_nxt = addr_lat + ADDR_W'(beat_nxt);
                end
            end
            ST_RD_TAIL: begin
                load_c    = 1'b1;
                state_nxt = TAIL_ST;
                wait_nxt  = '0;
            end
            ST_WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    state_nxt = ST_DONE;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                ready     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign idx_c    = IDX_W'(beat - 1'b1);
    assign rd_upd_c = (state_nxt == ST_DONE) && (state != ST_DONE) && !op_wr;

    sram_rd_assembler #(
        .BEATS   (BEATS),
        .SRAM_DW (SRAM_DW),
        .IDX_W   (IDX_W)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .load        (load_c),
        .idx         (idx_c),
        .din         (sram_dq),
        .word_next_c (word_next_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat      <= '0;
            wait_cnt  <= '0;
            addr_lat  <= '0;
            wr_lat    <= '0;
            op_wr     <= 1'b0;
            sram_we_n <= 1'b1;
            sram_addr <= '0;
            dq_out    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat      <= beat_nxt;
            wait_cnt  <= wait_nxt;
            sram_we_n <= we_n_nxt;
            sram_addr <= addr_nxt;
            dq_out    <= dout_nxt;
            rd_valid  <= rd_upd_c;
            if (accept_c) begin
                addr_lat <= addr_in[ADDR_W-1:0];
                wr_lat   <= wr_data;
                op_wr    <= mem_w_en;
            end
            if (rd_upd_c) begin
                rd_data <= word_next_c;
            end
        end
    end

    assign sram_dq = sram_we_n ? {SRAM_DW{1'bz}} : dq_out;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Scoreboard bench: two controller configurations, each against a behavioural 1-cycle-latency SRAM.
module tb_sram_word_ctrl;

    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int unsigned WW = (g == 0) ? 32 : 64;
        localparam int unsigned WC = (g == 0) ? 1 : 0;
        localparam int unsigned NB = WW / SRAM_DW;

        typedef struct {
            bit                wr;
            logic [ADDR_W-1:0] addr;
            logic [WW-1:0]     data;
            int                lat;
        } txn_t;

        logic                rst;
        logic                mem_w_en, mem_r_en;
        logic [31:0]         addr_in;
        logic [WW-1:0]       wr_data, rd_data;
        logic [ADDR_W-1:0]   sram_addr;
        logic                sram_we_n, rd_valid, ready;
        wire  [SRAM_DW-1:0]  sram_dq;

        logic [SRAM_DW-1:0]  mem     [DEPTH];
        logic [SRAM_DW-1:0]  ref_mem [DEPTH];
        logic [SRAM_DW-1:0]  model_q;
        logic                prev_we_n = 1'b0;
        logic                model_drive;

        txn_t          sb[$];
        txn_t          cur;
        bit            busy = 0;
        int            cyc = 0;
        int            done_cnt = 0;
        bit            fin = 0;
        logic [WW-1:0] last_rd;

        sram_word_ctrl #(
            .ADDR_W   (ADDR_W),
            .SRAM_DW  (SRAM_DW),
            .WORD_W   (WW),
            .WAIT_CYC (WC)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .mem_w_en  (mem_w_en),
            .mem_r_en  (mem_r_en),
            .addr_in   (addr_in),
            .wr_data   (wr_data),
            .sram_dq   (sram_dq),
            .sram_addr (sram_addr),
            .sram_we_n (sram_we_n),
            .rd_data   (rd_data),
            .rd_valid  (rd_valid),
            .ready     (ready)
        );

        // SRAM model: writes on we_n low, returns read data one cycle after the address.
        assign model_drive = prev_we_n & sram_we_n;
        assign sram_dq     = model_drive ? model_q : {SRAM_DW{1'bz}};

        always @(posedge clk) begin
            if (!sram_we_n) mem[sram_addr] = sram_dq;
            model_q   <= mem[sram_addr];
            prev_we_n <= sram_we_n;
        end

        // Monitor: completes the oldest expected transaction when ready is seen.
        always @(negedge clk) begin
            if (rst) begin
                busy = 0;
            end else begin
                if (!busy && sb.size() > 0) begin
                    cur  = sb.pop_front();
                    busy = 1;
                    cyc  = 0;
                end
                if (busy) begin
                    if (ready) begin
                        check("latency", 64'(cyc), 64'(cur.lat));
                        if (cur.wr) begin
                            check("wr_rd_valid", 64'(rd_valid), 64'd0);
                            check("wr_rd_data_kept", 64'(rd_data), 64'(last_rd));
                            for (int i = 0; i < NB; i++)
                                check("sram_mem", 64'(mem[ADDR_W'(cur.addr + i)]),
                                      64'(cur.data[i*SRAM_DW +: SRAM_DW]));
                        end else begin
                            check("rd_valid", 64'(rd_valid), 64'd1);
                            check("rd_data", 64'(rd_data), 64'(cur.data));
                            last_rd = cur.data;
                        end
                        busy = 0;
                        done_cnt++;
                    end else if (cyc > 40) begin
                        check("ready_timeout", 64'd0, 64'd1);
                        busy = 0;
                        done_cnt++;
                    end else begin
                        cyc++;
                    end
                end
            end
        end

        task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [63:0] d);
            txn_t t;
            int   seen;
            int   k;
            t.wr   = w;
            t.addr = a[ADDR_W-1:0];
            t.data = WW'(d);
            if (w) begin
                for (int i = 0; i < NB; i++)
                    ref_mem[ADDR_W'(t.addr + i)] = t.data[i*SRAM_DW +: SRAM_DW];
                t.lat = NB + WC + 1;
            end else begin
                for (int i = 0; i < NB; i++)
                    t.data[i*SRAM_DW +: SRAM_DW] = ref_mem[ADDR_W'(t.addr + i)];
                t.lat = NB + WC + 2;
            end
            @(posedge clk); #1;
            seen = done_cnt;
            sb.push_back(t);
            mem_w_en = w;
            mem_r_en = r;
            addr_in  = a;
            wr_data  = WW'(d);
            @(posedge clk); #1;
            // Operands are latched at accept; disturb them while busy.
            addr_in = $urandom;
            wr_data = WW'({$urandom, $urandom});
            k = 0;
            while (done_cnt == seen && k < 60) begin
                @(negedge clk); #1;
                k++;
            end
            check("handshake_in_budget", 64'(done_cnt != seen), 64'd1);
            mem_w_en = 1'b0;
            mem_r_en = 1'b0;
        endtask

        initial begin
            logic [ADDR_W-1:0] base;
            logic [31:0]       a;
            int unsigned       kind;
            rst      = 1'b1;
            mem_w_en = 1'b0;
            mem_r_en = 1'b0;
            addr_in  = '0;
            wr_data  = '0;
            last_rd  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]     = '0;
                ref_mem[i] = '0;
            end
            repeat (3) @(posedge clk);
            #1;
            check("rst_ready", 64'(ready), 64'd1);
            check("rst_we_n", 64'(sram_we_n), 64'd1);
            check("rst_addr", 64'(sram_addr), 64'd0);
            check("rst_rd_data", 64'(rd_data), 64'd0);
            check("rst_rd_valid", 64'(rd_valid), 64'd0);
            rst = 1'b0;

            issue(1'b1, 1'b0, 32'h0000_0100, 64'h0000_0000_DEAD_BEEF);
            issue(1'b0, 1'b1, 32'h0000_0100, 64'd0);
            issue(1'b1, 1'b1, 32'h0000_0020, 64'h0000_0000_1234_5678);
            issue(1'b1, 1'b0, 32'h0003_FFFF, 64'h0000_0000_CAFE_F00D);
            issue(1'b0, 1'b1, 32'h0003_FFFF, 64'd0);
            issue(1'b1, 1'b0, 32'h0000_0040, 64'h0123_4567_89AB_CDEF);
            issue(1'b0, 1'b1, 32'h0000_0040, 64'd0);

            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 3))
                    0:       base = '0;
                    1:       base = ADDR_W'(32'h100);
                    2:       base = ADDR_W'(DEPTH - 2);
                    default: base = ADDR_W'(32'h2A0);
                endcase
                a = $urandom;
                a[ADDR_W-1:0] = base + ADDR_W'($urandom_range(0, 3));
                kind = $urandom_range(0, 3);
                if (kind == 2)
                    issue(1'b0, 1'b1, a, 64'd0);
                else
                    issue(1'b1, kind == 3, a, {$urandom, $urandom});
            end

            // Make rd_data non-zero, then abort a read in its second beat.
            issue(1'b1, 1'b0, 32'h0000_0100, 64'hFEED_FACE_5A5A_A5A5);
            issue(1'b0, 1'b1, 32'h0000_0100, 64'd0);
            @(posedge clk); #1;
            mem_r_en = 1'b1;
            addr_in  = 32'h0000_0100;
            @(posedge clk);
            @(posedge clk); #1;
            rst      = 1'b1;
            mem_r_en = 1'b0;
            @(negedge clk);
            check("abort_ready", 64'(ready), 64'd1);
            check("abort_rd_data", 64'(rd_data), 64'd0);
            check("abort_we_n", 64'(sram_we_n), 64'd1);
            check("abort_addr", 64'(sram_addr), 64'd0);
            check("abort_rd_valid", 64'(rd_valid), 64'd0);
            last_rd = '0;
            @(posedge clk); #1;
            rst = 1'b0;
            issue(1'b0, 1'b1, 32'h0000_0100, 64'd0);
            repeat (2) @(posedge clk);
            fin = 1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(cfg[0].fin && cfg[1].fin) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        check("bench_complete", 64'(cfg[0].fin && cfg[1].fin), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
